// File: rtl/mem_stage.sv
// Data-memory stage: byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW on an internal little-endian
// word RAM with configurable access latency, handing results to write-back with a done pulse.
//
// state  | meaning
// IDLE   | waiting for ALU_kick_up; captures the request
// ACCESS | latency countdown; RAM access on the edge where cnt==0
// DONE   | MEM_kick_up high for this single cycle
module mem_stage #(
  parameter int MEM_DEPTH_WORDS = 256,
  parameter int ADDR_WIDTH      = 8,
  parameter int MEM_LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALU_result,
  input  logic [31:0] Read_data_2,
  input  logic        Controller_memread,
  input  logic        Controller_memwrite,
  input  logic [2:0]  Controller_memsize,
  input  logic        ALU_kick_up,
  output logic [31:0] MEM_read_data,
  output logic [31:0] MEM_alu_result,
  output logic        MEM_misaligned,
  output logic        MEM_busy,
  output logic        MEM_kick_up
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q, wdata_q;
  logic             rd_q, wr_q;
  logic [2:0]       size_q;
  logic             capture, do_access;

  logic [31:0] ram [MEM_DEPTH_WORDS];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]  lane;
  logic [31:0] cur_word, lane_shift, load_val, wdata_rep, merged;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [3:0]  wmask;
  logic        is_byte, is_half, fault;

  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    do_access   = 1'b0;
    MEM_busy    = 1'b0;
    MEM_kick_up = 1'b0;
    case (state)
      S_IDLE: begin
        if (ALU_kick_up) begin
          capture   = 1'b1;
          state_nxt = (Controller_memread || Controller_memwrite) ? S_ACCESS : S_DONE;
        end
      end
      S_ACCESS: begin
        MEM_busy = 1'b1;
        if (cnt == '0) begin
          do_access = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        MEM_busy    = 1'b1;
        MEM_kick_up = 1'b1;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Width decode uses size[1:0] only; reserved codes fall through to word.
  always_comb begin
    word_idx   = addr_q[ADDR_WIDTH+1:2];
    lane       = addr_q[1:0];
    cur_word   = ram[word_idx];
    is_byte    = (size_q[1:0] == 2'b00);
    is_half    = (size_q[1:0] == 2'b01);
    fault      = is_half ? addr_q[0] : (!is_byte && (lane != 2'b00));
    lane_shift = cur_word >> {lane, 3'b000};
    byte_v     = lane_shift[7:0];
    half_v     = addr_q[1] ? cur_word[31:16] : cur_word[15:0];
    if (is_byte)
      load_val = size_q[2] ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
    else if (is_half)
      load_val = size_q[2] ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
    else
      load_val = cur_word;
    if (is_byte) begin
      wmask     = 4'b0001 << lane;
      wdata_rep = {4{wdata_q[7:0]}};
    end else if (is_half) begin
      wmask     = addr_q[1] ? 4'b1100 : 4'b0011;
      wdata_rep = {2{wdata_q[15:0]}};
    end else begin
      wmask     = 4'b1111;
      wdata_rep = wdata_q;
    end
    for (int b = 0; b < 4; b++)
      merged[8*b +: 8] = wmask[b] ? wdata_rep[8*b +: 8] : cur_word[8*b +: 8];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rd_q           <= 1'b0;
      wr_q           <= 1'b0;
      size_q         <= '0;
      MEM_read_data  <= '0;
      MEM_alu_result <= '0;
      MEM_misaligned <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        addr_q  <= ALU_result;
        wdata_q <= Read_data_2;
        rd_q    <= Controller_memread;
        wr_q    <= Controller_memwrite;
        size_q  <= Controller_memsize;
        cnt     <= CNT_INIT;
        if (!(Controller_memread || Controller_memwrite)) begin
          MEM_alu_result <= ALU_result;
          MEM_read_data  <= '0;
          MEM_misaligned <= 1'b0;
        end
      end else if (state == S_ACCESS && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (do_access) begin
        MEM_alu_result <= addr_q;
        MEM_misaligned <= fault;
        MEM_read_data  <= (rd_q && !wr_q && !fault) ? load_val : 32'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_DEPTH_WORDS; i++) ram[i] <= '0;
    end else if (do_access && wr_q && !fault) begin
      ram[word_idx] <= merged;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: byte-array reference model feeding a scoreboard for a latency-1 instance,
// plus directed abort/reset checks on a latency-3 instance.
module tb_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int errors = 0;

  // latency-1 instance
  logic        reset;
  logic [31:0] alu, rs2;
  logic        rd, wr, kick;
  logic [2:0]  sz;
  logic [31:0] o_rdata, o_alu;
  logic        o_mis, o_busy, o_kick;

  mem_stage #(.MEM_DEPTH_WORDS(256), .ADDR_WIDTH(8), .MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .ALU_result(alu), .Read_data_2(rs2),
    .Controller_memread(rd), .Controller_memwrite(wr), .Controller_memsize(sz),
    .ALU_kick_up(kick), .MEM_read_data(o_rdata), .MEM_alu_result(o_alu),
    .MEM_misaligned(o_mis), .MEM_busy(o_busy), .MEM_kick_up(o_kick));

  // latency-3 instance
  logic        reset3;
  logic [31:0] alu3, rs23;
  logic        rd3, wr3, kick3;
  logic [2:0]  sz3;
  logic [31:0] o_rdata3, o_alu3;
  logic        o_mis3, o_busy3, o_kick3;

  mem_stage #(.MEM_DEPTH_WORDS(256), .ADDR_WIDTH(8), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset3), .ALU_result(alu3), .Read_data_2(rs23),
    .Controller_memread(rd3), .Controller_memwrite(wr3), .Controller_memsize(sz3),
    .ALU_kick_up(kick3), .MEM_read_data(o_rdata3), .MEM_alu_result(o_alu3),
    .MEM_misaligned(o_mis3), .MEM_busy(o_busy3), .MEM_kick_up(o_kick3));

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] alu;
    logic        mis;
    int          at_cyc;
    string       tag;
  } exp_t;
  exp_t sb[$];

  logic [7:0] mb [1024];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
    end
  endtask

  // Reference: 1 KiB byte array; address wraps modulo its size.
  function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic r,
                                input logic w, input logic [2:0] s,
                                output logic [31:0] rv, output logic mis);
    int n, base;
    logic [31:0] v;
    n    = (s[1:0] == 2'b00) ? 1 : (s[1:0] == 2'b01) ? 2 : 4;
    base = int'(a % 1024);
    rv   = 32'd0;
    mis  = (r || w) && (base % n != 0);
    if (mis) return;
    if (w) begin
      for (int i = 0; i < n; i++) mb[base+i] = d[8*i +: 8];
    end else if (r) begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v |= 32'(mb[base+i]) << (8*i);
      if (n < 4 && !s[2] && v[8*n-1]) v |= ~((32'd1 << (8*n)) - 32'd1);
      rv = v;
    end
  endfunction

  // Called at a negedge; optionally drives an extra kick while the DUT is busy.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic r,
                       input logic w, input logic [2:0] s, input bit extra, input string tag);
    exp_t e;
    int guard = 0;
    while (o_busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check({tag, "_busy_timeout"}, 32'd1, 32'd0);
    model(a, d, r, w, s, e.rdata, e.mis);
    e.alu    = a;
    e.at_cyc = cyc + 1 + ((r || w) ? 1 : 0);
    e.tag    = tag;
    sb.push_back(e);
    alu = a; rs2 = d; rd = r; wr = w; sz = s; kick = 1'b1;
    @(negedge clk);
    if (extra) begin
      alu = $urandom; rs2 = $urandom; rd = 1'b0; wr = 1'b1; sz = 3'b010;
      alu[9:0] = 10'h030;
      @(negedge clk);
    end
    kick = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && o_kick) begin
        if (sb.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL spurious_kick_up: got kick at cycle %0d want none", cyc);
        end else begin
          e = sb.pop_front();
          tests++;
          if (o_rdata !== e.rdata || o_alu !== e.alu || o_mis !== e.mis || cyc != e.at_cyc) begin
            errors++;
            $display("FAIL %s: got rd=0x%08h alu=0x%08h mis=%0b cyc=%0d want rd=0x%08h alu=0x%08h mis=%0b cyc=%0d",
                     e.tag, o_rdata, o_alu, o_mis, cyc, e.rdata, e.alu, e.mis, e.at_cyc);
          end
        end
      end
    end
  end

  task automatic run3(input logic [31:0] a, input logic [31:0] d, input logic r, input logic w,
                      input logic [2:0] s, output logic [31:0] rdat, output int lat);
    int start;
    alu3 = a; rs23 = d; rd3 = r; wr3 = w; sz3 = s; kick3 = 1'b1;
    start = cyc;
    @(negedge clk);
    kick3 = 1'b0;
    lat  = -1;
    rdat = 32'hxxxxxxxx;
    for (int i = 0; i < 20; i++) begin
      if (o_kick3) begin
        lat  = cyc - start;
        rdat = o_rdata3;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin : stim
    logic [31:0] r3;
    int          lat3, spur;
    logic [31:0] a;
    logic [1:0]  op;
    for (int i = 0; i < 1024; i++) mb[i] = 8'd0;
    reset = 1'b0; reset3 = 1'b0;
    alu = 0; rs2 = 0; rd = 0; wr = 0; sz = 0; kick = 0;
    alu3 = 0; rs23 = 0; rd3 = 0; wr3 = 0; sz3 = 0; kick3 = 0;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", {o_rdata | o_alu, 2'b00} | {32'd0, o_mis, o_busy, o_kick}, 34'd0);
    reset = 1'b1; reset3 = 1'b1;
    @(negedge clk);

    issue(32'h10, 32'hDEADBEEF, 0, 1, 3'b010, 0, "sw_10");
    issue(32'h10, 32'h0,        1, 0, 3'b010, 0, "lw_10");
    issue(32'h13, 32'h0,        1, 0, 3'b000, 0, "lb_13");
    issue(32'h13, 32'h0,        1, 0, 3'b100, 0, "lbu_13");
    issue(32'h12, 32'h0,        1, 0, 3'b001, 0, "lh_12");
    issue(32'h10, 32'h0,        1, 0, 3'b101, 0, "lhu_10");
    issue(32'h11, 32'h55,       0, 1, 3'b000, 0, "sb_11");
    issue(32'h10, 32'h0,        1, 0, 3'b010, 0, "lw_10_after_sb");
    issue(32'h12, 32'h1234,     0, 1, 3'b001, 0, "sh_12");
    issue(32'h10, 32'h0,        1, 0, 3'b010, 0, "lw_10_after_sh");
    issue(32'h22, 32'h0,        1, 0, 3'b010, 0, "lw_22_misaligned");
    issue(32'h21, 32'hABCD,     0, 1, 3'b001, 0, "sh_21_misaligned");
    issue(32'h20, 32'h0,        1, 0, 3'b010, 0, "lw_20_unchanged");
    issue(32'h7,  32'h0,        0, 0, 3'b010, 1, "alu_op_7");
    issue(32'h30, 32'h0,        1, 0, 3'b010, 0, "lw_30_ignored_kick");
    issue(32'h4,  32'h0,        1, 1, 3'b010, 0, "rd_wr_both");
    issue(32'h4,  32'h0,        1, 0, 3'b010, 0, "lw_4_after_both");
    issue(32'h0,  32'h13579BDF, 0, 1, 3'b010, 0, "sw_0");
    issue(32'h400, 32'h0,       1, 0, 3'b010, 0, "lw_400_alias");

    for (int i = 0; i < 150; i++) begin
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom << 10);
      op = 2'($urandom_range(0, 3));
      issue(a, $urandom, op[0], op[1], 3'($urandom_range(0, 7)),
            ($urandom_range(0, 7) == 0), $sformatf("rand_%0d", i));
    end

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    // latency-3: prior op leaves outputs non-zero, then a store is aborted by reset
    run3(32'h48, 32'hA5A5A5A5, 0, 1, 3'b010, r3, lat3);
    check("l3_sw_latency", 32'(lat3), 32'd4);
    run3(32'h48, 32'h0, 1, 0, 3'b010, r3, lat3);
    check("l3_lw_data", r3, 32'hA5A5A5A5);
    check("l3_lw_latency", 32'(lat3), 32'd4);
    alu3 = 32'h40; rs23 = 32'hCAFEF00D; rd3 = 0; wr3 = 1; sz3 = 3'b010; kick3 = 1'b1;
    @(negedge clk);
    kick3 = 1'b0;
    @(negedge clk);
    reset3 = 1'b0;
    #1;
    check("l3_abort_outputs", o_rdata3 | o_alu3, 32'd0);
    check("l3_abort_flags", {29'd0, o_mis3, o_busy3, o_kick3}, 32'd0);
    @(negedge clk);
    reset3 = 1'b1;
    spur = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_kick3) spur++;
    end
    check("l3_no_kick_after_abort", 32'(spur), 32'd0);
    run3(32'h40, 32'h0, 1, 0, 3'b010, r3, lat3);
    check("l3_aborted_store_absent", r3, 32'd0);
    run3(32'h48, 32'h0, 1, 0, 3'b010, r3, lat3);
    check("l3_ram_cleared", r3, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
